// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared types and constants for the character LCD path
package lcd_pkg;

  typedef enum logic [1:0] {
    WAIT_INIT = 2'd0,
    IDLE      = 2'd1,
    STROBE    = 2'd2,
    GAP       = 2'd3
  } feeder_state_t;

  localparam logic [7:0] LCD_CHAR_MIN   = 8'h20;
  localparam logic [7:0] LCD_CHAR_MAX   = 8'h7E;
  localparam int         LCD_GAP_CYCLES = 100;

  // True for bytes the LCD character generator can display directly.
  function automatic logic is_printable(input logic [7:0] b);
    return (b >= LCD_CHAR_MIN) && (b <= LCD_CHAR_MAX);
  endfunction

endpackage

// File: rtl/byte_fifo.sv
// rtl/byte_fifo.sv - synchronous byte FIFO with occupancy level
module byte_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [7:0]               push_data,
  input  logic                     pop,
  output logic [7:0]               pop_data,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  // Head of queue is always visible so the caller can register it on pop.
  assign pop_data = mem[rd_ptr];

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers and level; simultaneous push and pop leaves the level unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/lcd_char_feeder.sv
// rtl/lcd_char_feeder.sv - filters, buffers and paces characters to the LCD driver
module lcd_char_feeder
  import lcd_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int GAP_CYCLES = LCD_GAP_CYCLES
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic [7:0]               in_byte,
  output logic                     in_ready,
  input  logic                     init_complete,
  output logic                     ready,
  output logic [7:0]               msg_byte,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic [7:0]               dropped_count
);

  localparam int LW = $clog2(DEPTH) + 1;
  localparam int CW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [CW-1:0] GAP_LOAD = CW'(GAP_CYCLES - 1);

  feeder_state_t state, state_nxt;
  logic [CW-1:0] gap_cnt, gap_cnt_nxt;
  logic          ready_nxt;
  logic [7:0]    msg_nxt;
  logic [7:0]    head;
  logic          accept, push, drop, pop;

  // Only the registered level gates acceptance, so a same-cycle pop never frees a slot early.
  assign in_ready = (fifo_level < LW'(DEPTH));
  assign accept   = in_valid && in_ready;
  assign push     = accept && is_printable(in_byte);
  assign drop     = accept && !is_printable(in_byte);

  byte_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (in_byte),
    .pop       (pop),
    .pop_data  (head),
    .level     (fifo_level)
  );

  // Saturating count of discarded control bytes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dropped_count <= '0;
    end else if (drop && (dropped_count != 8'hFF)) begin
      dropped_count <= dropped_count + 8'd1;
    end
  end

  // Pacing state, strobe and gap counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= WAIT_INIT;
      ready    <= 1'b0;
      msg_byte <= 8'h00;
      gap_cnt  <= '0;
    end else begin
      state    <= state_nxt;
      ready    <= ready_nxt;
      msg_byte <= msg_nxt;
      gap_cnt  <= gap_cnt_nxt;
    end
  end

  // Next-state logic: pop in IDLE, one strobe cycle, then a full gap countdown.
  always_comb begin
    state_nxt   = state;
    ready_nxt   = 1'b0;
    msg_nxt     = msg_byte;
    gap_cnt_nxt = gap_cnt;
    pop         = 1'b0;
    case (state)
      WAIT_INIT: begin
        if (init_complete) begin
          state_nxt = IDLE;
        end
      end
      IDLE: begin
        if (!init_complete) begin
          state_nxt = WAIT_INIT;
        end else if (fifo_level != '0) begin
          pop       = 1'b1;
          ready_nxt = 1'b1;
          msg_nxt   = head;
          state_nxt = STROBE;
        end
      end
      STROBE: begin
        gap_cnt_nxt = GAP_LOAD;
        state_nxt   = GAP;
      end
      GAP: begin
        if (gap_cnt == '0) begin
          state_nxt = init_complete ? IDLE : WAIT_INIT;
        end else begin
          gap_cnt_nxt = gap_cnt - CW'(1);
        end
      end
      default: state_nxt = WAIT_INIT;
    endcase
  end

endmodule

// File: tb/tb_lcd_char_feeder.sv
// tb/tb_lcd_char_feeder.sv - self-checking bench for lcd_char_feeder
module tb_lcd_char_feeder;

  localparam int DEPTH = 16;
  localparam int GAP   = 12;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic [7:0]    in_byte = 8'h00;
  logic          in_ready;
  logic          init_complete = 1'b0;
  logic          ready;
  logic [7:0]    msg_byte;
  logic [LW-1:0] fifo_level;
  logic [7:0]    dropped_count;

  lcd_char_feeder #(.DEPTH(DEPTH), .GAP_CYCLES(GAP)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_byte       (in_byte),
    .in_ready      (in_ready),
    .init_complete (init_complete),
    .ready         (ready),
    .msg_byte      (msg_byte),
    .fifo_level    (fifo_level),
    .dropped_count (dropped_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input bit ok, input string name, input int act, input int req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Reference model: ordered list of displayable bytes not yet strobed out.
  logic [7:0] mq[$];
  int         mdrop = 0;
  bit         mon_en = 1'b0;
  bit         pend_acc = 1'b0;
  logic [7:0] pend_byte = 8'h00;
  bit         ready_prev = 1'b0;
  bit         init_prev = 1'b0;
  logic [7:0] last_msg = 8'h00;
  logic [7:0] exp_b;
  int         cyc = 0;
  int         last_strobe = -1;
  int         last_gap = 0;
  int         nstrobes = 0;

  always @(negedge clk) begin
    cyc++;
    if (mon_en) begin
      if (pend_acc) begin
        if (pend_byte >= 8'h20 && pend_byte <= 8'h7E) mq.push_back(pend_byte);
        else if (mdrop < 255) mdrop++;
      end
      if (ready) begin
        chk(!ready_prev, "ready_two_cycles", 1, 0);
        chk(init_prev, "strobe_while_init_low", 0, 1);
        if (mq.size() == 0) begin
          chk(1'b0, "unexpected_strobe", msg_byte, -1);
        end else begin
          exp_b = mq.pop_front();
          chk(msg_byte == exp_b, "strobe_byte", msg_byte, exp_b);
        end
        if (last_strobe >= 0) begin
          last_gap = cyc - last_strobe;
          chk(last_gap >= GAP + 2, "strobe_spacing", last_gap, GAP + 2);
        end
        last_strobe = cyc;
        last_msg    = msg_byte;
        nstrobes++;
      end else begin
        chk(msg_byte == last_msg, "msg_hold", msg_byte, last_msg);
      end
      chk(fifo_level == mq.size(), "fifo_level", fifo_level, mq.size());
      chk(dropped_count == mdrop, "dropped_count", dropped_count, mdrop);
      chk(in_ready == (mq.size() < DEPTH), "in_ready", in_ready, mq.size() < DEPTH);
    end
    ready_prev = ready;
    init_prev  = init_complete;
    pend_acc   = in_valid && in_ready && rst_n;
    pend_byte  = in_byte;
  end

  task automatic do_reset();
    mon_en   = 1'b0;
    in_valid = 1'b0;
    rst_n    = 1'b0;
    repeat (2) @(posedge clk);
    mq.delete();
    mdrop = 0; last_strobe = -1; last_msg = 8'h00; ready_prev = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    mon_en = 1'b1;
  endtask

  // Offers one byte and returns one time step after the edge that took it.
  task automatic push_byte(input logic [7:0] b);
    int n = 0;
    in_valid = 1'b1;
    in_byte  = b;
    while (!in_ready && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk(in_ready, "push_timeout", in_ready, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (!(mq.size() == 0 && fifo_level == 0) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk(mq.size() == 0 && fifo_level == 0, "drain_timeout", mq.size(), 0);
    repeat (GAP + 3) @(posedge clk);
    #1;
  endtask

  task automatic wait_strobe(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(negedge clk);
      if (ready) seen = 1'b1;
    end
    chk(seen, "strobe_timeout", seen, 1);
  endtask

  typedef struct {
    logic [7:0] b;
    int         exp_level;
    int         exp_drop;
  } vec_t;
  vec_t tbl[9];

  initial begin
    bit seen;
    int s0;
    tbl[0] = '{8'h41, 1, 0};
    tbl[1] = '{8'h0A, 1, 1};
    tbl[2] = '{8'h7F, 1, 2};
    tbl[3] = '{8'h42, 2, 2};
    tbl[4] = '{8'h1F, 2, 3};
    tbl[5] = '{8'h20, 3, 3};
    tbl[6] = '{8'h7E, 4, 3};
    tbl[7] = '{8'h80, 4, 4};
    tbl[8] = '{8'hFF, 4, 5};

    do_reset();
    chk(ready == 1'b0, "rst_ready", ready, 0);
    chk(msg_byte == 8'h00, "rst_msg", msg_byte, 0);
    chk(fifo_level == 0, "rst_level", fifo_level, 0);
    chk(dropped_count == 0, "rst_drop", dropped_count, 0);
    chk(in_ready == 1'b1, "rst_in_ready", in_ready, 1);

    // "HI" held until init completes, then two exactly spaced strobes.
    push_byte(8'h48);
    push_byte(8'h49);
    repeat (GAP) @(negedge clk);
    chk(fifo_level == 2, "hi_level", fifo_level, 2);
    chk(nstrobes == 0, "hi_no_strobe", nstrobes, 0);
    init_complete = 1'b1;
    drain();
    chk(nstrobes == 2, "hi_strobes", nstrobes, 2);
    chk(last_gap == GAP + 2, "hi_spacing", last_gap, GAP + 2);

    // Filter table, back to back, including range boundaries.
    init_complete = 1'b0;
    repeat (GAP + 3) @(posedge clk);
    #1;
    s0 = nstrobes;
    foreach (tbl[i]) begin
      push_byte(tbl[i].b);
      @(negedge clk);
      chk(fifo_level == tbl[i].exp_level, "tbl_level", fifo_level, tbl[i].exp_level);
      chk(dropped_count == tbl[i].exp_drop, "tbl_drop", dropped_count, tbl[i].exp_drop);
    end
    @(posedge clk);
    #1 init_complete = 1'b1;
    drain();
    chk(nstrobes - s0 == 4, "tbl_strobes", nstrobes - s0, 4);

    // Fill to DEPTH with init low, then release and finish the 20 bytes.
    do_reset();
    init_complete = 1'b0;
    s0 = nstrobes;
    for (int i = 0; i < 16; i++) push_byte(8'h30 + 8'(i));
    @(negedge clk);
    chk(in_ready == 1'b0, "full_in_ready", in_ready, 0);
    chk(fifo_level == 16, "full_level", fifo_level, 16);
    @(posedge clk);
    #1 init_complete = 1'b1;
    for (int i = 16; i < 20; i++) push_byte(8'h30 + 8'(i));
    drain();
    chk(nstrobes - s0 == 20, "full_strobes", nstrobes - s0, 20);

    // Single byte into an empty FIFO while IDLE.
    in_valid = 1'b1;
    in_byte  = 8'h55;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk(ready == 1'b0, "lat_edge_n", ready, 0);
    @(negedge clk);
    chk(ready == 1'b1, "lat_edge_n1", ready, 1);
    chk(msg_byte == 8'h55, "lat_byte", msg_byte, 8'h55);
    @(negedge clk);
    chk(ready == 1'b0, "lat_edge_n2", ready, 0);
    drain();

    // init_complete drops mid-GAP with three bytes still queued.
    init_complete = 1'b0;
    for (int i = 0; i < 4; i++) push_byte(8'h61 + 8'(i));
    init_complete = 1'b1;
    wait_strobe(seen);
    repeat (3) @(posedge clk);
    #1 init_complete = 1'b0;
    s0 = nstrobes;
    repeat (4 * (GAP + 2)) @(negedge clk);
    chk(nstrobes == s0, "hold_no_strobe", nstrobes - s0, 0);
    chk(fifo_level == 3, "hold_level", fifo_level, 3);
    @(posedge clk);
    #1 init_complete = 1'b1;
    drain();
    chk(nstrobes - s0 == 3, "hold_resume", nstrobes - s0, 3);

    // Randomized traffic with init_complete toggling.
    for (int c = 0; c < 400; c++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_byte  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255))
                                             : 8'($urandom_range(32, 126));
      if ($urandom_range(0, 39) == 0) init_complete = ~init_complete;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    init_complete = 1'b1;
    drain();

    // Asynchronous reset in the middle of a strobe.
    do_reset();
    push_byte(8'h4A);
    push_byte(8'h4B);
    wait_strobe(seen);
    mon_en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk(ready == 1'b0, "areset_ready", ready, 0);
    chk(fifo_level == 0, "areset_level", fifo_level, 0);
    chk(msg_byte == 8'h00, "areset_msg", msg_byte, 0);
    do_reset();

    // Dropped-byte counter saturation.
    for (int i = 0; i < 256; i++) push_byte(8'($urandom_range(0, 31)));
    @(negedge clk);
    chk(dropped_count == 8'd255, "drop_saturate", dropped_count, 255);
    chk(fifo_level == 0, "drop_level", fifo_level, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL global_timeout actual=%0d required=%0d", cyc, 0);
    $fatal(1, "timeout");
  end

endmodule
